// File: rtl/encoder_emu_pkg.sv
// Shared types and quadrature tables for the rotary encoder emulator.
// Table entries are {A,B}; index 0 is the first phase after leaving detent.
package encoder_emu_pkg;

  typedef enum logic [1:0] {
    OP_LEFT  = 2'b00,
    OP_RIGHT = 2'b01,
    OP_PRESS = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROT,
    ST_GAP,
    ST_PRESS,
    ST_RELEASE
  } state_e;

  // Left: A rises while B=0; right: A rises while B=1.
  localparam logic [3:0][1:0] LEFT_SEQ  = {2'b11, 2'b10, 2'b00, 2'b01};
  localparam logic [3:0][1:0] RIGHT_SEQ = {2'b11, 2'b01, 2'b00, 2'b10};

endpackage

// File: rtl/rotary_encoder_emulator_tick_timer.sv
// Loadable down-counter; holds at zero and flags terminal count there.
// Loading N-1 yields a flag after exactly N cycles in the loading state.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk_2kHZ,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_2kHZ or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/rotary_encoder_emulator.sv
// Transmit side of the rotary encoder interface: emits A/B quadrature steps
// and SW presses with timing the board's encoder decoder qualifies cleanly.
module rotary_encoder_emulator
  import encoder_emu_pkg::*;
#(
  parameter int PHASE_TICKS   = 4,
  parameter int GAP_TICKS     = 8,
  parameter int PRESS_TICKS   = 100,
  parameter int RELEASE_TICKS = 100,
  parameter int CNT_W         = 8
) (
  input  logic             clk_2kHZ,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             oA,
  output logic             oB,
  output logic             oSW,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int T_MAX_A = (PHASE_TICKS > GAP_TICKS) ? PHASE_TICKS : GAP_TICKS;
  localparam int T_MAX_B = (PRESS_TICKS > RELEASE_TICKS) ? PRESS_TICKS : RELEASE_TICKS;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0] PHASE_LD   = TIMER_W'(PHASE_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LD     = TIMER_W'(GAP_TICKS - 1);
  localparam logic [TIMER_W-1:0] PRESS_LD   = TIMER_W'(PRESS_TICKS - 1);
  localparam logic [TIMER_W-1:0] RELEASE_LD = TIMER_W'(RELEASE_TICKS - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             a_q, a_d, b_q, b_d, sw_q, sw_d, done_q, done_d;

  logic                   tmr_load;
  logic [TIMER_W-1:0]     tmr_val;
  logic                   tmr_tc;
  logic [3:0][1:0]        seq;

  tick_timer #(.W(TIMER_W)) u_timer (
    .clk_2kHZ   (clk_2kHZ),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk_2kHZ or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LEFT;
      phase_q <= 2'd0;
      steps_q <= '0;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
      sw_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      phase_q <= phase_d;
      steps_q <= steps_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
    end
  end

  assign seq = (op_q == OP_RIGHT) ? RIGHT_SEQ : LEFT_SEQ;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    phase_d  = phase_q;
    steps_d  = steps_q;
    a_d      = a_q;
    b_d      = b_q;
    sw_d     = sw_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        a_d  = 1'b1;
        b_d  = 1'b1;
        sw_d = 1'b1;
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          tmr_load = 1'b1;
          // Null commands take one RELEASE cycle so done lands a cycle later.
          state_d  = ST_RELEASE;
          tmr_val  = '0;
          if ((op_e'(cmd_op) == OP_LEFT || op_e'(cmd_op) == OP_RIGHT) && cmd_count != '0) begin
            state_d    = ST_ROT;
            phase_d    = 2'd0;
            steps_d    = cmd_count;
            tmr_val    = PHASE_LD;
            {a_d, b_d} = (op_e'(cmd_op) == OP_RIGHT) ? RIGHT_SEQ[0] : LEFT_SEQ[0];
          end else if (op_e'(cmd_op) == OP_PRESS) begin
            state_d = ST_PRESS;
            sw_d    = 1'b0;
            tmr_val = PRESS_LD;
          end
        end
      end

      ST_ROT: begin
        if (tmr_tc) begin
          if (phase_q != 2'd3) begin
            phase_d    = phase_q + 2'd1;
            {a_d, b_d} = seq[phase_q + 2'd1];
            tmr_load   = 1'b1;
            tmr_val    = PHASE_LD;
            if (phase_q == 2'd2 && steps_q != '0) begin
              steps_d = steps_q - CNT_W'(1);
            end
          end else if (steps_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end

      ST_GAP: begin
        if (tmr_tc) begin
          state_d    = ST_ROT;
          phase_d    = 2'd0;
          {a_d, b_d} = seq[0];
          tmr_load   = 1'b1;
          tmr_val    = PHASE_LD;
        end
      end

      ST_PRESS: begin
        if (tmr_tc) begin
          state_d  = ST_RELEASE;
          sw_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = RELEASE_LD;
        end
      end

      ST_RELEASE: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign oA         = a_q;
  assign oB         = b_q;
  assign oSW        = sw_q;
  assign done       = done_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_rotary_encoder_emulator.sv
// Directed bench for rotary_encoder_emulator with default timing parameters;
// a small A-rise monitor plays the role of the decoder's direction logic.
`timescale 1ns/1ps
module tb_rotary_encoder_emulator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_ready, oA, oB, oSW, busy, done;
  logic [CNT_W-1:0] steps_left;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int   n_left = 0, n_right = 0, n_tog = 0;
  logic a_prev = 1'b1, b_prev = 1'b1, sw_prev = 1'b1;

  rotary_encoder_emulator #(
    .PHASE_TICKS(4), .GAP_TICKS(8), .PRESS_TICKS(100), .RELEASE_TICKS(100), .CNT_W(CNT_W)
  ) dut (
    .clk_2kHZ   (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .oA         (oA),
    .oB         (oB),
    .oSW        (oSW),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A rising with B low is a left detent, with B high a right detent.
  always @(negedge clk) begin
    if (!a_prev && oA) begin
      if (!oB) n_left <= n_left + 1;
      else     n_right <= n_right + 1;
    end
    if (oA != a_prev || oB != b_prev || oSW != sw_prev) n_tog <= n_tog + 1;
    a_prev  <= oA;
    b_prev  <= oB;
    sw_prev <= oSW;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for a single edge; acceptance edge time is recorded.
  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input string tag);
    chk({tag, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_done_latency"}, cyc - acc_cyc, exp_lat);
      tick();
      chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int l0, r0, t0, low_len;
    bit early;

    // Reset values while rst is held
    tick();
    tick();
    chk("rst_oA", {31'd0, oA}, 32'd1);
    chk("rst_oB", {31'd0, oB}, 32'd1);
    chk("rst_oSW", {31'd0, oSW}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_steps", {24'd0, steps_left}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Left x3: 3*16 + 2*8 = 64 cycles, three left detents
    l0 = n_left; r0 = n_right;
    issue(2'b00, 8'd3, "left3");
    chk("left3_steps0", {24'd0, steps_left}, 32'd3);
    chk("left3_ab_ph0", {30'd0, oA, oB}, 32'b01);
    wait_done(64, "left3");
    chk("left3_nleft", n_left - l0, 32'd3);
    chk("left3_nright", n_right - r0, 32'd0);

    // Right x1: phases (1,0),(0,0),(0,1),(1,1), 4 cycles each
    l0 = n_left; r0 = n_right;
    issue(2'b01, 8'd1, "right1");
    chk("right1_ab_c0", {30'd0, oA, oB}, 32'b10);
    chk("right1_steps_c0", {24'd0, steps_left}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      if (i == 3)  chk("right1_ab_c3", {30'd0, oA, oB}, 32'b10);
      if (i == 4)  chk("right1_ab_c4", {30'd0, oA, oB}, 32'b00);
      if (i == 8)  chk("right1_ab_c8", {30'd0, oA, oB}, 32'b01);
      if (i == 11) chk("right1_steps_c11", {24'd0, steps_left}, 32'd1);
      if (i == 12) chk("right1_ab_c12", {30'd0, oA, oB}, 32'b11);
      if (i == 12) chk("right1_steps_c12", {24'd0, steps_left}, 32'd0);
    end
    wait_done(16, "right1");
    chk("right1_nright", n_right - r0, 32'd1);
    chk("right1_nleft", n_left - l0, 32'd0);

    // Press: SW low 100 cycles, released 100 more, done at 200
    issue(2'b10, 8'd0, "press");
    chk("press_sw_low", {31'd0, oSW}, 32'd0);
    low_len = 0;
    for (int k = 0; k < 500 && !oSW; k++) begin
      tick();
      low_len = cyc - acc_cyc;
    end
    chk("press_low_len", low_len, 32'd100);
    wait_done(200, "press");

    // Reserved op and zero-count rotate: no pin activity, done one cycle later
    t0 = n_tog;
    issue(2'b11, 8'd5, "rsvd");
    wait_done(1, "rsvd");
    issue(2'b00, 8'd0, "left0");
    wait_done(1, "left0");
    tick();
    chk("null_toggles", n_tog - t0, 32'd0);

    // Back-to-back: press held valid during a left step, taken after done
    cmd_op    = 2'b00;
    cmd_count = 8'd1;
    cmd_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    cmd_op  = 2'b10;
    early   = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (!oSW) early = 1'b1;
    end
    chk("b2b_left_latency", cyc - acc_cyc, 32'd16);
    chk("b2b_no_early_press", {31'd0, early}, 32'd0);
    chk("b2b_ready_on_done", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    chk("b2b_press_taken", {31'd0, oSW}, 32'd0);
    chk("b2b_press_busy", {31'd0, busy}, 32'd1);
    wait_done(200, "b2b_press");

    // Reset asserted mid-rotation, in phase1
    issue(2'b00, 8'd2, "rstmid");
    for (int i = 0; i < 4; i++) tick();
    chk("rstmid_ph1_ab", {30'd0, oA, oB}, 32'b00);
    rst = 1'b1;
    #1;
    chk("rstmid_oA", {31'd0, oA}, 32'd1);
    chk("rstmid_oB", {31'd0, oB}, 32'd1);
    chk("rstmid_oSW", {31'd0, oSW}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_steps", {24'd0, steps_left}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rstmid_hold_a", {31'd0, oA}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rotary_encoder_emulator.md
Name: rotary_encoder_emulator

Overview:
- Generates A/B quadrature and SW push-button waveforms, the transmit side of the rotary-encoder interface.
- Uses board-compatible timing, so the existing encoder decoder (2 kHz sampler, 20 ms switch sampling) reports exact left/right/press events.
- Used for in-system self-test and for benches that need a realistic encoder source.
- Accepts step and press commands over a valid/ready handshake.

Parameters:
- PHASE_TICKS, 4: clk_2kHZ cycles each quadrature phase is held. Minimum 2, required by the decoder's two-sample qualification.
- GAP_TICKS, 8: cycles held at detent (A=1, B=1) between consecutive steps.
- PRESS_TICKS, 100: cycles SW is held low (50 ms). Must be ≥ 2 × the decoder's 40-tick switch sampling period.
- RELEASE_TICKS, 100: cycles SW is held high after a press before the next command is accepted.
- CNT_W, 8: width of the step count.

Ports:
- clk_2kHZ  in  1  block clock, 500 us period
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 = rotate left, 01 = rotate right, 10 = press, 11 = reserved
- cmd_count  in  CNT_W  number of detent steps (rotate ops only)
- oA  out  1  encoder A pin
- oB  out  1  encoder B pin
- oSW  out  1  encoder switch pin, active-low
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- steps_left  out  CNT_W  remaining steps of the current rotate command

Behaviour:
Reset and handshake
- Reset is rst, asynchronous, active-high; the clock is clk_2kHZ.
- While rst is high: oA=1, oB=1, oSW=1, busy=0, done=0, steps_left=0, state=IDLE, cmd_ready=1 (combinational from IDLE).
- Reset asserted mid-operation returns the outputs to the detent/released levels immediately and discards the command.
- A command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_op and cmd_count are latched at that edge.
- cmd_ready = (state==IDLE). It drops the cycle after acceptance.
- Op 11, or a rotate op with cmd_count=0: no pin activity. done pulses the cycle after acceptance and the block returns to IDLE.

State machine (IDLE, ROT, GAP, PRESS, RELEASE)
- IDLE → ROT on a rotate accept. steps_left=cmd_count, phase index=0, timer=0.
- IDLE → PRESS on a press accept. oSW=0 on the next edge.
- Phase encoding is (A,B); the timer counts 0..N-1 per phase.
- Left sequence: phase0 (0,1), phase1 (0,0), phase2 (1,0), phase3 (1,1). A rises while B=0, which the decoder reports as left.
- Right sequence: phase0 (1,0), phase1 (0,0), phase2 (0,1), phase3 (1,1). A rises while B=1, which the decoder reports as right.
- Each phase is held exactly PHASE_TICKS cycles. Exactly one of A or B changes per transition (Gray code, no glitches).
- Entering phase3 decrements steps_left.
- At the end of phase3: if steps_left==0, go to IDLE with done pulsed that cycle. Otherwise go to GAP.
- GAP holds (1,1) for GAP_TICKS, then returns to ROT phase0.
- Duration of one detent = 4·PHASE_TICKS. An N-step command lasts N·4·PHASE_TICKS + (N−1)·GAP_TICKS cycles.
- PRESS: oSW=0 for PRESS_TICKS, then oSW=1 and go to RELEASE.
- RELEASE: hold oSW=1 for RELEASE_TICKS, then go to IDLE with done pulsed.
- busy=1 in every state except IDLE.
- oA, oB and oSW are registered outputs (no combinational paths to the pins).
- Counters saturate at their terminal value and reload on each state entry; no wrap-around is possible.
- cmd_valid outside IDLE is ignored. The command is not latched, and the source must hold it.

Decomposition:
- Package encoder_emu_pkg holds:
  - op codes: OP_LEFT, OP_RIGHT, OP_PRESS, OP_RSVD
  - state enum
  - phase tables: LEFT_SEQ, RIGHT_SEQ as 4×2-bit constants
- One sub-module, tick_timer: a loadable down-counter with a terminal-count flag, instantiated once and shared by all states.

Test Plan:
- Reset mid-ROT at phase1 → oA=1, oB=1, oSW=1, busy=0 immediately. cmd_ready=1 after rst deasserts.
- Left, count=3, PHASE_TICKS=4, GAP_TICKS=8 → 3 A-rises each with B=0. done exactly 3·16+2·8=64 cycles after acceptance. The decoder asserts left 3 times and right 0 times.
- Right, count=1 → pins follow (1,0),(0,0),(0,1),(1,1), 4 cycles each. The decoder asserts right once. steps_left goes 1→0 at phase3.
- Press → oSW low for exactly 100 cycles, then high for 100 cycles. done at cycle 200. The decoder reports left=right=1 once, within 40 ticks of the falling edge.
- Op 11, then a rotate op with count=0 → no pin toggles. done is pulsed 1 cycle after each acceptance.
- cmd_valid held high with a second command during busy → second command accepted only on the first IDLE cycle after done. Check with a back-to-back left then press.
